event_window_ctrl: RTL

Measurement sequencer that arms, gates and reads out an event counter over a programmable window of clock cycles. Software or an upstream FSM issues start. The block waits for a trigger, then counts rising edges of evt_in for exactly win_len cycles. It returns the result over a valid/ready handshake. It is the control layer for the counter datapath.

---
 rtl/event_window_ctrl.sv | 83 ++++++++
 1 files changed

// File: rtl/event_window_ctrl.sv
// event_window_ctrl: arms on start, waits for trig, counts evt_in rising edges over win_len cycles, hands the result over valid/ready.
// Define EVT_SATURATE_EN to make the accumulator saturate instead of wrapping.
module event_window_ctrl #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic             trig,
    input  logic             abort,
    input  logic             evt_in,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] count_out,
    output logic             ovf,
    output logic [1:0]       state_out
);
    typedef enum logic [1:0] {IDLE = 2'b00, ARMED = 2'b01, COUNT = 2'b10, DONE = 2'b11} state_t;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] acc, acc_inc;
    logic [WIN_W-1:0] win_rem;
    logic             evt_q, ovf_int, rise, at_max, ovf_inc, last;
    assign rise    = evt_in & ~evt_q;
    assign at_max  = &acc;
    assign ovf_inc = ovf_int | (rise & at_max);
    assign last    = win_rem == WIN_W'(1);
`ifdef EVT_SATURATE_EN
    assign acc_inc = (rise && !at_max) ? acc + CNT_W'(1) : acc;
`else
    assign acc_inc = acc + CNT_W'(rise);
`endif
    assign busy      = (state == ARMED) || (state == COUNT);
    assign res_valid = state == DONE;
    assign state_out = state;
    always_comb begin
        state_nxt = state;
        if (abort) state_nxt = IDLE;
        else begin
            case (state)
                IDLE:  if (start) state_nxt = (win_len == '0) ? DONE : ARMED;
                ARMED: if (trig) state_nxt = COUNT;
                COUNT: if (last) state_nxt = DONE;
                DONE:  if (res_ready) state_nxt = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            acc       <= '0;
            win_rem   <= '0;
            evt_q     <= 1'b0;
            ovf_int   <= 1'b0;
            count_out <= '0;
            ovf       <= 1'b0;
        end else begin
            state <= state_nxt;
            evt_q <= evt_in;
            if (!abort && state == IDLE && start) begin
                win_rem <= win_len;
                acc     <= '0;
                ovf_int <= 1'b0;
                if (win_len == '0) begin
                    count_out <= '0;
                    ovf       <= 1'b0;
                end
            end
            // abort discards the window, so the published result is only touched on completion
            if (!abort && state == COUNT) begin
                acc     <= acc_inc;
                ovf_int <= ovf_inc;
                win_rem <= win_rem - WIN_W'(1);
                if (last) begin
                    count_out <= acc_inc;
                    ovf       <= ovf_inc;
                end
            end
        end
    end
endmodule
